// File: rtl/uart_word_loader.sv
// Assembles a length-prefixed byte stream from a UART receiver into 32-bit
// memory writes at consecutive word addresses starting at BASE_ADDR.
module uart_word_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_wr_ready,
  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [1:0] {IDLE, LEN, DATA, WRITE} state_t;

  localparam logic [31:0] GAP_LAST = TIMEOUT_CYCLES - 1;

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [31:0] gap;
  logic        done_r, error_r;
  logic        fire_done, fire_error;
  logic        timeout;

  always_comb begin
    state_nxt  = state;
    fire_done  = 1'b0;
    fire_error = 1'b0;
    timeout    = (gap == GAP_LAST);
    case (state)
      IDLE: begin
        if (i_valid) state_nxt = LEN;
      end
      LEN: begin
        if (i_valid) begin
          if ({i_data, len[7:0]} == 16'h0000) begin
            fire_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end else if (timeout) begin
          fire_error = 1'b1;
          state_nxt  = IDLE;
        end
      end
      DATA: begin
        if (i_valid) begin
          if (byte_idx == 2'd3) state_nxt = WRITE;
        end else if (timeout) begin
          fire_error = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WRITE: begin
        // A byte arriving while the write is pending is an overrun and wins
        // over a simultaneous write acceptance.
        if (i_valid) begin
          fire_error = 1'b1;
          state_nxt  = IDLE;
        end else if (i_wr_ready) begin
          if (word_idx == len - 16'd1) begin
            fire_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word     <= '0;
      gap      <= '0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_r  <= fire_done;
      error_r <= fire_error;
      case (state)
        IDLE: begin
          word_idx <= '0;
          byte_idx <= '0;
          gap      <= '0;
          if (i_valid) len <= {8'h00, i_data};
        end
        LEN: begin
          if (i_valid) begin
            len[15:8] <= i_data;
            gap       <= '0;
          end else begin
            gap <= gap + 32'd1;
          end
        end
        DATA: begin
          if (i_valid) begin
            word[{byte_idx, 3'b000} +: 8] <= i_data;
            byte_idx                      <= byte_idx + 2'd1;
            gap                           <= '0;
          end else begin
            gap <= gap + 32'd1;
          end
        end
        WRITE: begin
          gap <= '0;
          if (!i_valid && i_wr_ready) word_idx <= word_idx + 16'd1;
        end
        default: gap <= '0;
      endcase
    end
  end

  assign o_wr_en   = (state == WRITE);
  assign o_busy    = (state != IDLE);
  assign o_addr    = BASE_ADDR + {14'b0, word_idx, 2'b00};
  assign o_wr_data = word;
  assign o_done    = done_r;
  assign o_error   = error_r;

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: table of frames plus hand sequences for overrun,
// timeout and mid-frame reset; writes are checked against a scoreboard queue.
module tb_uart_word_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned TMO  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = '0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic        o_wr_en, o_busy, o_done, o_error;
  logic [31:0] o_addr, o_wr_data;

  always #5 clk = ~clk;

  uart_word_loader #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .i_wr_ready(ready), .o_wr_en(o_wr_en), .o_addr(o_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cycles;
  } exp_t;

  typedef struct {
    int unsigned  n;
    logic [127:0] w;
    int unsigned  stall;
    int           exp_done;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int unsigned stall_cfg = 0;
  int unsigned wr_cycles = 0;
  logic [31:0] hold_addr, hold_data;
  logic        prev_done = 1'b0;
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: drives i_wr_ready after stall_cfg cycles, checks each write.
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_cycles = 0;
      ready     = 1'b0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (o_done) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
        check("done_err_excl", 32'(o_error), 32'd0);
      end
      if (o_error) begin
        err_cnt++;
        check("err_width", 32'(prev_err), 32'd0);
      end
      prev_done = o_done;
      prev_err  = o_error;
      if (o_wr_en) begin
        if (wr_cycles == 0) begin
          hold_addr = o_addr;
          hold_data = o_wr_data;
        end else begin
          check("addr_stable", o_addr, hold_addr);
          check("data_stable", o_wr_data, hold_data);
        end
        wr_cycles++;
        ready = (wr_cycles > stall_cfg);
        if (ready) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", o_addr, e.addr);
            check("wr_data", o_wr_data, e.data);
            check("wr_en_cycles", wr_cycles, e.cycles);
          end
        end
      end else begin
        wr_cycles = 0;
        ready     = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit wait_wr);
    int unsigned guard = 0;
    if (wait_wr) begin
      while (o_wr_en && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard == 200) check("wr_en_release", 32'(o_wr_en), 32'd0);
    end
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic run_frame(input int unsigned n, input logic [127:0] w,
                           input int unsigned stall, input bit expect_writes);
    exp_t e;
    stall_cfg = stall;
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (b == 0 && expect_writes) begin
          e.addr   = BASE + 32'(4 * i);
          e.data   = w[32*i +: 32];
          e.cycles = stall + 1;
          sb.push_back(e);
        end
        send_byte(w[32*i + 8*b +: 8], 1'b1);
      end
    end
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned guard = 0;
    while (o_busy && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    if (guard == budget) check("busy_timeout", 32'(o_busy), 32'd0);
    @(negedge clk);
  endtask

  vec_t vt[5];
  int   d0, e0, first;

  initial begin
    vt[0] = '{n: 2, w: {64'h0, 32'h88776655, 32'h44332211}, stall: 0, exp_done: 1};
    vt[1] = '{n: 0, w: 128'h0, stall: 0, exp_done: 1};
    vt[2] = '{n: 1, w: {96'h0, 32'hDEADBEEF}, stall: 5, exp_done: 1};
    vt[3] = '{n: 3, w: {32'h0, 32'h0BADF00D, 32'h12345678, 32'hA5A55A5A}, stall: 2, exp_done: 1};
    vt[4] = '{n: 4, w: {32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'h13579BDF}, stall: 1, exp_done: 1};

    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_addr", o_addr, BASE);
    check("rst_data", o_wr_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      run_frame(vt[v].n, vt[v].w, vt[v].stall, 1'b1);
      wait_idle(300);
      check($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 32'(vt[v].exp_done));
      check($sformatf("vec%0d_err", v), 32'(err_cnt - e0), 32'd0);
      check($sformatf("vec%0d_sb_empty", v), 32'(sb.size()), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(o_busy), 32'd0);
    end

    // Empty frame: done one cycle after the second length byte.
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("n0_done_pulse", 32'(o_done), 32'd1);
    check("n0_busy", 32'(o_busy), 32'd0);
    check("n0_wr_en", 32'(o_wr_en), 32'd0);
    @(negedge clk);
    check("n0_done_low", 32'(o_done), 32'd0);

    // Overrun during a stalled write.
    d0 = done_cnt;
    e0 = err_cnt;
    stall_cfg = 1000;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1'b0);
    check("ovr_wr_en_high", 32'(o_wr_en), 32'd1);
    repeat (2) @(negedge clk);
    send_byte(8'hEE, 1'b0);
    check("ovr_error", 32'(o_error), 32'd1);
    check("ovr_wr_en_low", 32'(o_wr_en), 32'd0);
    check("ovr_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("ovr_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("ovr_err_cnt", 32'(err_cnt - e0), 32'd1);
    d0 = done_cnt;
    run_frame(1, {96'h0, 32'hCAFEBABE}, 0, 1'b1);
    wait_idle(300);
    check("ovr_next_done", 32'(done_cnt - d0), 32'd1);
    check("ovr_next_sb", 32'(sb.size()), 32'd0);

    // Gap timeout after two data bytes.
    e0 = err_cnt;
    stall_cfg = 0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    first = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (o_error && first == 0) first = k;
    end
    check("tmo_cycle", 32'(first), 32'(TMO));
    check("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("tmo_busy", 32'(o_busy), 32'd0);
    d0 = done_cnt;
    run_frame(1, {96'h0, 32'h01020304}, 0, 1'b1);
    wait_idle(300);
    check("tmo_next_done", 32'(done_cnt - d0), 32'd1);

    // Reset after two data bytes.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_wr_en", 32'(o_wr_en), 32'd0);
    check("mrst_busy", 32'(o_busy), 32'd0);
    check("mrst_done", 32'(o_done), 32'd0);
    check("mrst_error", 32'(o_error), 32'd0);
    check("mrst_addr", o_addr, BASE);
    check("mrst_data", o_wr_data, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mrst_no_err", 32'(err_cnt - e0), 32'd0);
    run_frame(1, {96'h0, 32'h55AA55AA}, 0, 1'b1);
    wait_idle(300);
    check("mrst_next_done", 32'(done_cnt - d0), 32'd1);

    // Reset while a write is pending.
    d0 = done_cnt;
    e0 = err_cnt;
    stall_cfg = 1000;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'hC0 + 8'(b), 1'b0);
    check("wrst_wr_en_high", 32'(o_wr_en), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("wrst_wr_en_low", 32'(o_wr_en), 32'd0);
    check("wrst_addr", o_addr, BASE);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("wrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("wrst_no_err", 32'(err_cnt - e0), 32'd0);
    run_frame(2, {64'h0, 32'h0F0E0D0C, 32'h03020100}, 0, 1'b1);
    wait_idle(300);
    check("wrst_next_done", 32'(done_cnt - d0), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, maximum idle gap in clocks between bytes within a frame (10 ms at 100 MHz).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset; synchronous, active-low.
REQ-005 i_data  input  8  received byte from the UART receiver.
REQ-006 i_valid  input  1  one-cycle strobe; i_data is valid in that cycle.
REQ-007 i_wr_ready  input  1  memory accepts the write in the current cycle.
REQ-008 o_wr_en  output  1  memory write request.
REQ-009 o_addr  output  32  byte address of the write.
REQ-010 o_wr_data  output  32  assembled word.
REQ-011 o_busy  output  1  high when the block is not in IDLE.
REQ-012 o_done  output  1  one-cycle pulse when a frame completes.
REQ-013 o_error  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 Frame format SHALL be a 16-bit little-endian word count N, then N*4 data bytes, each word little-endian (first byte -> bits 7:0).
REQ-015 States SHALL be IDLE, LEN, DATA and WRITE.
REQ-016 IDLE: on i_valid, capture the byte as N[7:0] and go to LEN; otherwise remain in IDLE.
REQ-017 LEN: on i_valid, capture N[15:8]; if N==0, pulse o_done next cycle and go to IDLE; else go to DATA with byte index 0 and word index 0.
REQ-018 DATA: on i_valid, place the byte at lane byte_idx of o_wr_data and increment byte_idx (2-bit, wraps); on the 4th byte go to WRITE.
REQ-019 o_wr_en SHALL assert in the cycle after the 4th byte is accepted and remain high throughout WRITE.
REQ-020 o_addr SHALL equal BASE_ADDR + 4*word_idx, using 32-bit wrap-around arithmetic; o_addr and o_wr_data SHALL be stable while o_wr_en is high.
REQ-021 WRITE: when i_wr_ready is high, the write completes; o_wr_en drops next cycle; increment word_idx.
REQ-022 WRITE completion with word_idx == N-1: pulse o_done next cycle and go to IDLE.
REQ-023 WRITE completion otherwise: return to DATA.
REQ-024 i_valid while in WRITE (overrun) SHALL abort the frame, regardless of i_wr_ready in that cycle.
  - Abort actions: drop o_wr_en, pulse o_error, go to IDLE; the byte is discarded.
REQ-025 Timeout (LEN and DATA only) SHALL use a gap counter.
  - Counter clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES, pulse o_error and go to IDLE.
  - The counter SHALL NOT run in IDLE or WRITE.
REQ-026 o_done and o_error SHALL never assert in the same cycle and SHALL each be high for exactly one cycle per event.
REQ-027 After done or error, the next i_valid in IDLE SHALL start a new frame, with word_idx restarting at 0.
REQ-028 o_busy SHALL be a registered or state-decoded signal: high in LEN, DATA and WRITE.

Reset
REQ-029 While i_rst_n is low at a clock edge, the block SHALL go to IDLE.
  - o_wr_en, o_busy, o_done and o_error SHALL be 0.
  - o_addr SHALL be BASE_ADDR and o_wr_data SHALL be 0.
  - All counters and indices SHALL clear.
REQ-030 Reset asserted mid-frame, including during WRITE with o_wr_en high, SHALL abandon the frame without o_done or o_error.
REQ-031 The first byte accepted after reset release SHALL be treated as N[7:0].

Verification
REQ-032 Bytes 02 00 11 22 33 44 55 66 77 88 with i_wr_ready tied 1 -> writes 0x44332211 @ 0x0 and 0x88776655 @ 0x4, then o_done pulses once.
REQ-033 Bytes 00 00 -> no o_wr_en; o_done pulses one cycle after the 2nd byte; o_busy returns to 0.
REQ-034 N=1, i_wr_ready held 0 for 5 cycles -> o_wr_en high for 6 cycles with o_addr and o_wr_data stable; single write, then o_done.
REQ-035 N=1, i_valid pulsed during WRITE stall -> o_error pulse, o_wr_en drops, no o_done; the next frame writes at BASE_ADDR.
REQ-036 TIMEOUT_CYCLES=50, N=1, send 2 data bytes then idle -> o_error pulses exactly 50 cycles after the last byte; a following frame completes normally.
REQ-037 Reset asserted during DATA after 2 of 4 bytes -> all outputs are at reset values next cycle; no o_done or o_error; a fresh frame succeeds.
